// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Round-robin arbiter that lets two requesters share one combinational ALU.
// A grant captures the winner's operands and select code into registers that
// drive the ALU. The ALU result is captured one cycle later and held until
// the consumer acknowledges it. Only one operation is in flight at a time.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req0/req1             operation requests
//   op0/op1 [2:0]         ALU select code per requester
//   a0,b0/a1,b1 [3:0]     operands per requester
//   gnt0/gnt1             one-cycle grant pulse, operands captured
//   alu_a, alu_b [3:0]    registered operands to the shared ALU
//   alu_select [2:0]      registered select to the shared ALU
//   alu_out [4:0]         combinational result from the shared ALU
//   res [4:0]             captured result
//   res_valid             res holds an unacknowledged result
//   res_id                requester that owns res
//   res_ack               result consumer acknowledge
//   busy                  high whenever the FSM is not IDLE
//
// Optional feature (macro ALU_ARBITER_GRANT_CNT_EN)
//   cnt0/cnt1 [7:0]       wrapping per-requester grant counters
// ---------------------------------------------------------------------------
module alu_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] op0,
  input  logic [2:0] op1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_select,
  input  logic [4:0] alu_out,
  output logic [4:0] res,
  output logic       res_valid,
  output logic       res_id,
  input  logic       res_ack,
  output logic       busy
`ifdef ALU_ARBITER_GRANT_CNT_EN
  ,
  output logic [7:0] cnt0,
  output logic [7:0] cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       last_id_q, last_id_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [2:0] alu_select_q, alu_select_d;
  logic [4:0] res_q, res_d;
  logic       res_valid_q, res_valid_d;
  logic       res_id_q, res_id_d;

  // Requester 1 wins when it asks alone, or on a tie when requester 0 was
  // the last one served.
  logic win1;
  assign win1 = req1 & (~req0 | ~last_id_q);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    last_id_d    = last_id_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_select_d = alu_select_q;
    res_d        = res_q;
    res_valid_d  = res_valid_q;
    res_id_d     = res_id_q;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          alu_a_d      = win1 ? a1  : a0;
          alu_b_d      = win1 ? b1  : b0;
          alu_select_d = win1 ? op1 : op0;
          gnt0_d       = ~win1;
          gnt1_d       = win1;
          last_id_d    = win1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        // last_id_q still names the requester granted on the previous edge.
        res_d       = alu_out;
        res_id_d    = last_id_q;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_ack) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_id_q    <= 1'b1;   // requester 0 wins the first tie
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      alu_a_q      <= 4'b0000;
      alu_b_q      <= 4'b0000;
      alu_select_q <= 3'b000;
      res_q        <= 5'b00000;
      res_valid_q  <= 1'b0;
      res_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_id_q    <= last_id_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_select_q <= alu_select_d;
      res_q        <= res_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_select = alu_select_q;
  assign res        = res_q;
  assign res_valid  = res_valid_q;
  assign res_id     = res_id_q;
  assign busy       = (state_q != IDLE);

`ifdef ALU_ARBITER_GRANT_CNT_EN
  logic [7:0] cnt0_q, cnt0_d;
  logic [7:0] cnt1_q, cnt1_d;

  // Counters advance on the same edge that raises the grant; 8-bit
  // arithmetic wraps 255 -> 0 naturally.
  always_comb begin
    cnt0_d = gnt0_d ? cnt0_q + 8'd1 : cnt0_q;
    cnt1_d = gnt1_d ? cnt1_q + 8'd1 : cnt1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter. A bench-side ALU drives alu_out from the
// DUT's registered operands (op 000: a+b, op 001: a-b, 5 bits). Each issued
// operation pushes its expected owner and result into a scoreboard queue;
// the entry is popped and compared when res_valid rises. A round-robin
// model tracks the expected winner on every issue.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [2:0] op0, op1;
  logic [3:0] a0, b0, a1, b1;
  logic       gnt0, gnt1;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_select;
  logic [4:0] alu_out;
  logic [4:0] res;
  logic       res_valid;
  logic       res_id;
  logic       res_ack;
  logic       busy;
`ifdef ALU_ARBITER_GRANT_CNT_EN
  logic [7:0] cnt0, cnt1;
`endif

  alu_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (req0),
    .req1       (req1),
    .op0        (op0),
    .op1        (op1),
    .a0         (a0),
    .b0         (b0),
    .a1         (a1),
    .b1         (b1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_select (alu_select),
    .alu_out    (alu_out),
    .res        (res),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_ack    (res_ack),
    .busy       (busy)
`ifdef ALU_ARBITER_GRANT_CNT_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  always #5 clk = ~clk;

  // Shared ALU environment model.
  always_comb begin
    if (alu_select == 3'b001) alu_out = {1'b0, alu_a} - {1'b0, alu_b};
    else                      alu_out = {1'b0, alu_a} + {1'b0, alu_b};
  end

  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct packed {
    logic       id;
    logic [4:0] res;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        m_last;
  int unsigned last_gnt_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] exp_res(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    if (op == 3'b001) return {1'b0, a} - {1'b0, b};
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_gnt0"},       gnt0,       0);
    check({tag, "_gnt1"},       gnt1,       0);
    check({tag, "_res_valid"},  res_valid,  0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_res_id"},     res_id,     0);
    check({tag, "_alu_a"},      alu_a,      0);
    check({tag, "_alu_b"},      alu_b,      0);
    check({tag, "_alu_select"}, alu_select, 0);
    check({tag, "_res"},        res,        0);
`ifdef ALU_ARBITER_GRANT_CNT_EN
    check({tag, "_cnt0"},       cnt0,       0);
    check({tag, "_cnt1"},       cnt1,       0);
`endif
  endtask

  // Called at a negedge with requests already driven; the next rising edge
  // must grant. Returns at the negedge where the grant is visible (EXEC).
  task automatic issue(input string tag);
    exp_t e;
    logic w;
    int   waited;
    w      = (req0 && req1) ? !m_last : req1;
    m_last = w;
    e.id   = w;
    e.res  = w ? exp_res(op1, a1, b1) : exp_res(op0, a0, b0);
    sb.push_back(e);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(gnt0 || gnt1) && waited < 20);
    check({tag, "_gnt_latency"}, waited, 1);
    check({tag, "_gnt0"}, gnt0, !w);
    check({tag, "_gnt1"}, gnt1, w);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_alu_select"}, alu_select, w ? op1 : op0);
    check({tag, "_alu_a"}, alu_a, w ? a1 : a0);
    check({tag, "_alu_b"}, alu_b, w ? b1 : b0);
    last_gnt_cyc = cyc_cnt;
    if (w) req1 = 1'b0;
    else   req0 = 1'b0;
  endtask

  // Result phase: check the scoreboard entry, hold for 'hold' cycles without
  // ack, then acknowledge and check the return to IDLE.
  task automatic complete(input string tag, input int hold);
    exp_t e;
    @(negedge clk);
    check({tag, "_gnt_pulse0"}, gnt0, 0);
    check({tag, "_gnt_pulse1"}, gnt1, 0);
    check({tag, "_res_valid"}, res_valid, 1);
    e = '0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_res"}, res, e.res);
      check({tag, "_res_id"}, res_id, e.id);
    end else begin
      check({tag, "_sb_size"}, sb.size(), 1);
    end
    res_ack = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, res_valid, 1);
      check({tag, "_hold_res"}, res, e.res);
      check({tag, "_hold_nognt"}, gnt0 | gnt1, 0);
      check({tag, "_hold_busy"}, busy, 1);
    end
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    check({tag, "_ack_valid"}, res_valid, 0);
    check({tag, "_ack_busy"}, busy, 0);
    check({tag, "_ack_res_kept"}, res, e.res);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    int unsigned prev_cyc;

    rst_n = 1'b0; res_ack = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    op0 = 3'b000; op1 = 3'b000;
    a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
    m_last = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    // Single request, first grant right after reset release.
    req0 = 1'b1; op0 = 3'b000; a0 = 4'b0100; b0 = 4'b0010;
    issue("single0");
    complete("single0", 0);

    // Single request from requester 1, subtraction wrapping negative.
    req1 = 1'b1; op1 = 3'b001; a1 = 4'd2; b1 = 4'd7;
    issue("single1");
    complete("single1", 0);

    // Tie held for three grants: order 0,1,0 at the minimum interval.
    op0 = 3'b000; a0 = 4'd9; b0 = 4'd8;
    op1 = 3'b001; a1 = 4'd3; b1 = 4'd5;
    req0 = 1'b1; req1 = 1'b1;
    issue("tie1");
    prev_cyc = last_gnt_cyc;
    complete("tie1", 0);
    req0 = 1'b1;
    issue("tie2");
    check("tie2_interval", last_gnt_cyc - prev_cyc, 3);
    prev_cyc = last_gnt_cyc;
    complete("tie2", 0);
    req1 = 1'b1;
    issue("tie3");
    check("tie3_interval", last_gnt_cyc - prev_cyc, 3);
    complete("tie3", 0);
    issue("tie_tail");
    complete("tie_tail", 0);

    // Backpressure: requester 1 arrives during EXEC and waits out HOLD.
    req0 = 1'b1; op0 = 3'b000; a0 = 4'd15; b0 = 4'd15;
    issue("bp");
    req1 = 1'b1; op1 = 3'b000; a1 = 4'd6; b1 = 4'd1;
    complete("bp", 10);
    issue("bp_next");
    complete("bp_next", 0);

    // Stray ack in IDLE, then held through the grant and EXEC edges.
    res_ack = 1'b1;
    @(negedge clk);
    check("stray_idle_busy", busy, 0);
    check("stray_idle_valid", res_valid, 0);
    req0 = 1'b1; op0 = 3'b001; a0 = 4'd8; b0 = 4'd3;
    issue("stray");
    complete("stray", 2);

    // Reset while HOLD: result discarded, tie afterwards favours 0.
    req0 = 1'b1; op0 = 3'b000; a0 = 4'd1; b0 = 4'd1;
    issue("rh");
    @(negedge clk);
    check("rh_valid", res_valid, 1);
    check("rh_busy", busy, 1);
    e = sb.pop_front();
    check("rh_res", res, e.res);
    rst_n = 1'b0;
    #1;
    check_reset("rh_async");
    @(negedge clk);
    check_reset("rh_held");
    rst_n = 1'b1;
    m_last = 1'b1;
    op0 = 3'b001; a0 = 4'd12; b0 = 4'd4;
    op1 = 3'b000; a1 = 4'd5; b1 = 4'd5;
    req0 = 1'b1; req1 = 1'b1;
    issue("rh_tie");
    complete("rh_tie", 0);
    issue("rh_tail");
    complete("rh_tail", 0);

`ifdef ALU_ARBITER_GRANT_CNT_EN
    // 257 grants to requester 0 wrap cnt0 through 255 back to 1.
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("cnt_rst");
    rst_n = 1'b1;
    m_last = 1'b1;
    op0 = 3'b000; a0 = 4'd3; b0 = 4'd4;
    for (int i = 0; i < 257; i++) begin
      req0 = 1'b1;
      issue("cnt");
      complete("cnt", 0);
    end
    check("cnt0_wrap", cnt0, 1);
    check("cnt1_idle", cnt1, 0);
`endif

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n; all other ports are listed after them.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req0, req1  input  1 each  operation request from requester 0 / 1.
REQ-005 op0, op1  input  3 each  ALU select code from requester 0 / 1.
REQ-006 a0, b0, a1, b1  input  4 each  operands from requester 0 / 1.
REQ-007 gnt0, gnt1  output  1 each  one-cycle grant pulse; operands captured.
REQ-008 alu_a, alu_b  output  4 each  registered operands driven to the shared ALU.
REQ-009 alu_select  output  3  registered select driven to the shared ALU.
REQ-010 alu_out  input  5  combinational result returned by the shared ALU.
REQ-011 res  output  5  captured result.
REQ-012 res_valid  output  1  res holds an unacknowledged result.
REQ-013 res_id  output  1  requester that owns res (0 or 1).
REQ-014 res_ack  input  1  result consumer acknowledge.
REQ-015 busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, EXEC and HOLD.
REQ-017 IDLE SHALL behave as follows at each rising edge when req0 or req1 is high:
- Select the winner.
- Load alu_a, alu_b and alu_select from the winner's operands.
- Assert the winner's gnt for exactly one cycle.
- Go to EXEC.
REQ-018 Arbitration SHALL be round-robin over a last_id register: if only one request is high, it wins; if both are high, the requester not equal to last_id wins, and last_id updates to the winner.
REQ-019 EXEC SHALL last exactly one cycle. At its closing edge it SHALL:
- Capture alu_out into res.
- Set res_id to the winner.
- Set res_valid to 1.
- Go to HOLD.
REQ-020 HOLD SHALL remain until res_ack is sampled high. On that edge, res_valid SHALL clear and the state SHALL go to IDLE.
REQ-021 Latency SHALL be one cycle from the request-sampling edge to gnt, and two cycles from that edge to res_valid. The minimum issue interval SHALL be three cycles.
REQ-022 res_ack sampled outside HOLD SHALL be ignored.
REQ-023 A req still high on the first IDLE edge after a grant SHALL be treated as a new request. Requesters hold req, op and operands stable until gnt and drop req on gnt.
REQ-024 Requests arriving in EXEC or HOLD SHALL NOT be granted, SHALL NOT be lost, and SHALL be arbitrated on return to IDLE.
REQ-025 alu_a, alu_b, alu_select, res and res_id SHALL hold their values until next overwritten.
REQ-026 The result SHALL be passed through at the full 5-bit width with no truncation or extension.

Reset
REQ-027 While rst_n is low, the following SHALL clear asynchronously and hold: state=IDLE; gnt0, gnt1, res_valid, busy, res_id = 0; alu_a, alu_b = 4'b0000; alu_select = 3'b000; res = 5'b00000; last_id = 1 (so requester 0 wins the first tie).
REQ-028 Reset asserted mid-operation (in EXEC or HOLD) SHALL discard the in-flight operation without any result being issued.
REQ-029 The first grant SHALL be possible at the first rising edge after rst_n deasserts.

Configuration
REQ-030 With macro ALU_ARBITER_GRANT_CNT_EN defined, the block SHALL add the following:
- Outputs cnt0 and cnt1, 8 bits each.
- Each counter increments on every gnt of its requester.
- Each counter wraps from 255 to 0.
- Both counters reset to 0.
REQ-031 Without ALU_ARBITER_GRANT_CNT_EN, cnt0, cnt1 and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
The bench ALU model drives alu_out = a+b for op 000 and a-b (5-bit) for op 001.
REQ-032 Single request: req0=1, op0=000, a0=0100, b0=0010 -> gnt0 one cycle later; two cycles later res=00110, res_id=0, res_valid=1.
REQ-033 Tie: req0 and req1 both held high for 3 grants -> grant order 0,1,0, each issue at least 3 cycles apart.
REQ-034 Backpressure: res_ack low for 10 cycles while req1 is pending -> res_valid stays 1, res is stable and no gnt1 occurs; res_ack=1 -> gnt1 two edges later.
REQ-035 Reset in HOLD: rst_n low for 1 cycle while res_valid=1 -> all outputs take their REQ-027 values, and the next tie grants requester 0.
REQ-036 Stray ack: res_ack=1 while in IDLE and in EXEC -> no state change and res_valid is unaffected.
REQ-037 With ALU_ARBITER_GRANT_CNT_EN: 257 grants to requester 0 -> cnt0=1, cnt1=0.
